multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
Sequencer for the shared HI/LO multiply/divide resource in the EX stage. It accepts one operation per start strobe and holds the operands for a fixed multi-cycle latency. It generates the busy flag that the pipeline hazard unit uses to stall HI/LO-class instructions in ID, and it commits results to the HI/LO registers. It honours the exception-flush disable so that a flushed instruction never modifies HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles after the start cycle for multiply-class ops (>=1)
DIV_CYCLES, 10, busy cycles after the start cycle for divide ops (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle strobe: valid op in EX this cycle
op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others NONE
rs_val  in  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source)
rt_val  in  32  forwarded rt operand (divisor / multiplier)
dis  in  1  flush disable from pipeline control; blocks acceptance this cycle
busy  out  1  to hazard unit; = accept_long | (state != IDLE)
hi  out  32  HI register
lo  out  32  LO register
div_zero  out  1  sticky flag: last accepted divide had rt_val==0; cleared on next accepted divide

Behaviour:
- Reset: state IDLE, counter 0, hi=0, lo=0, div_zero=0, busy=0. Reset asserted mid-operation aborts it; HI/LO return to 0.
- accept = start & ~dis & (state==IDLE) & op is a valid code. accept_long = accept & op in {1,2,3,4,7..10}.
- Start while not IDLE: ignored, no state change. The hazard unit guarantees this does not occur; the bench asserts it never happens.
- FSM states: IDLE, MUL, DIV.
- IDLE to MUL on accept of op 1,2,7..10. Latch operands and op, load counter=MULT_CYCLES.
- IDLE to DIV on accept of op 3,4. Latch operands, load counter=DIV_CYCLES.
- MUL/DIV: counter decrements each cycle. At the edge where counter==1, commit the result to HI/LO and go to IDLE.
- Timing: start in cycle 0. busy is high in cycles 0..N (N = MULT_CYCLES or DIV_CYCLES). New hi/lo are visible from cycle N+1, when busy=0.
- MTHI/MTLO: accepted only in IDLE. Write rs_val to hi or lo at the end of cycle 0. busy stays 0.
- MULT: {hi,lo} = signed 32x32 to 64-bit product. MULTU: unsigned product.
- DIV: signed division truncating toward zero. lo=quotient, hi=remainder, and the remainder takes the sign of the dividend. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- DIVU: unsigned division.
- Divide by zero: full DIV_CYCLES busy, HI/LO unchanged, div_zero=1.
- Results are computed from the latched operands, not from live inputs. Operand changes during busy have no effect.
- dis asserted while in MUL/DIV: the operation continues and commits. It was accepted before the flush, and the instruction has already committed architecturally.
- dis and start in the same cycle: nothing is accepted, nothing is written, and busy stays 0 that cycle.

Optional Feature:
MULTDIV_MADD_EN.
- Defined: ops 7..10 are valid. MADD adds the signed product to {hi,lo}. MADDU adds the unsigned product. MSUB subtracts the signed product from {hi,lo}. MSUBU subtracts the unsigned product. Arithmetic is modulo 2^64, uses the {hi,lo} value at commit time, and takes MULT_CYCLES.
- Undefined: ops 7..10 are treated as NONE (not accepted, busy stays 0). No accumulate adder is synthesised.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3, start cycle 0: busy=1 in cycles 0..5. From cycle 6, hi=0xFFFFFFFF and lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2: busy cycles 0..10. Then lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
- DIVU rs=100, rt=0, with hi/lo preloaded 0x11/0x22 via MTHI/MTLO: after 11 busy cycles, hi=0x11, lo=0x22, div_zero=1.
- MULTU start with dis=1: busy=0 in every cycle and hi/lo unchanged. Repeat with dis=0, then raise dis in cycle 2: the result still commits at cycle 6.
- Reset pulsed in cycle 3 of a DIV: busy=0 immediately, hi=lo=0, state IDLE. A subsequent MTLO 0x5 gives lo=0x5 the next cycle.
- With MULTDIV_MADD_EN defined: preload hi=0, lo=0xFFFFFFFF, then MADDU 1*1 gives hi=1, lo=0. Without the macro, the same op leaves busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, commits on last count.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops enabled by `define MULTDIV_MADD_EN.
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        dis,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULTDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [CNT_W-1:0] L_MUL = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] L_DIV = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [31:0]      r_rs;
    logic [31:0]      r_rt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_dz;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_valid;
    logic        w_accept;
    logic        w_accept_long;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_mul_res;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: w_is_mul = 1'b1;
            OP_DIV, OP_DIVU:   w_is_div = 1'b1;
`ifdef MULTDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_is_mul = 1'b1;
`endif
            default: ;
        endcase
        w_valid = w_is_mul | w_is_div | (op == OP_MTHI) | (op == OP_MTLO);
    end

    assign w_accept      = start & ~dis & (r_state == S_IDLE) & w_valid;
    assign w_accept_long = w_accept & (w_is_mul | w_is_div);

    // Sign-extending to 64 bits lets one unsigned multiply give the signed low half.
    assign w_prod_s = {{32{r_rs[31]}}, r_rs} * {{32{r_rt[31]}}, r_rt};
    assign w_prod_u = {32'b0, r_rs} * {32'b0, r_rt};

    always_comb begin
        w_mul_res = w_prod_s;
        case (r_op)
            OP_MULTU: w_mul_res = w_prod_u;
`ifdef MULTDIV_MADD_EN
            OP_MADD:  w_mul_res = {r_hi, r_lo} + w_prod_s;
            OP_MADDU: w_mul_res = {r_hi, r_lo} + w_prod_u;
            OP_MSUB:  w_mul_res = {r_hi, r_lo} - w_prod_s;
            OP_MSUBU: w_mul_res = {r_hi, r_lo} - w_prod_u;
`endif
            default: ;
        endcase
    end

    // Magnitude divide; signs reapplied so quotient truncates toward zero.
    assign w_neg_a = (r_op == OP_DIV) & r_rs[31];
    assign w_neg_b = (r_op == OP_DIV) & r_rt[31];
    assign w_abs_a = w_neg_a ? (32'd0 - r_rs) : r_rs;
    assign w_abs_b = w_neg_b ? (32'd0 - r_rt) : r_rt;
    assign w_q_mag = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_r_mag = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_quo   = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 4'd0;
            r_rs    <= 32'd0;
            r_rt    <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_dz    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op == OP_MTHI) begin
                            r_hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            r_lo <= rs_val;
                        end else begin
                            r_op <= op;
                            r_rs <= rs_val;
                            r_rt <= rt_val;
                            if (w_is_div) begin
                                r_state <= S_DIV;
                                r_cnt   <= L_DIV;
                                r_dz    <= (rt_val == 32'd0);
                            end else begin
                                r_state <= S_MUL;
                                r_cnt   <= L_MUL;
                            end
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - L_ONE;
                    if (r_cnt == L_ONE) begin
                        r_hi    <= w_mul_res[63:32];
                        r_lo    <= w_mul_res[31:0];
                        r_state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt - L_ONE;
                    if (r_cnt == L_ONE) begin
                        if (r_rt != 32'd0) begin
                            r_lo <= w_quo;
                            r_hi <= w_rem;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = w_accept_long | (r_state != S_IDLE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_dz;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: expected HI/LO/div_zero queued at issue,
// popped and compared once the busy window closes.
module tb_multdiv_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        dis;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int errs   = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sbq[$];

    multdiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .dis(dis),
        .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Issue one op at cycle 0, check busy in cycles 0..nb, compare at cycle nb+1.
    task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int nb, input logic d0,
                       input int dis_at, input exp_t e);
        exp_t got;
        chk({tag, "/idle_before"}, busy, 0);
        sbq.push_back(e);
        start = 1'b1; op = o; rs_val = a; rt_val = b; dis = d0;
        @(negedge clk);
        chk({tag, "/busy_c0"}, busy, (nb > 0) ? 1 : 0);
        nxt();
        start = 1'b0; op = 4'd0; rs_val = $urandom; rt_val = $urandom; dis = 1'b0;
        for (int k = 1; k <= nb; k++) begin
            if (k == dis_at) dis = 1'b1;
            @(negedge clk);
            chk({tag, "/busy_mid"}, busy, 1);
            nxt();
        end
        dis = 1'b0;
        @(negedge clk);
        chk({tag, "/busy_end"}, busy, 0);
        got = sbq.pop_front();
        chk({tag, "/hi"}, hi, got.hi);
        chk({tag, "/lo"}, lo, got.lo);
        chk({tag, "/dz"}, div_zero, got.dz);
        nxt();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0;
        rs_val = 32'd0; rt_val = 32'd0; dis = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        chk("rst/busy", busy, 0);
        chk("rst/hi", hi, 0);
        chk("rst/lo", lo, 0);
        chk("rst/dz", div_zero, 0);
        nxt();
        reset = 1'b0;
        nxt();

        run("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b0, -1,
            '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA, dz: 1'b0});
        run("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, -1,
            '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dz: 1'b0});
        run("mthi", 4'd5, 32'h11, 32'd0, 0, 1'b0, -1,
            '{hi: 32'h11, lo: 32'hFFFFFFFD, dz: 1'b0});
        run("mtlo", 4'd6, 32'h22, 32'd0, 0, 1'b0, -1,
            '{hi: 32'h11, lo: 32'h22, dz: 1'b0});
        run("divu0", 4'd4, 32'd100, 32'd0, 10, 1'b0, -1,
            '{hi: 32'h11, lo: 32'h22, dz: 1'b1});
        run("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, -1,
            '{hi: 32'h0, lo: 32'h80000000, dz: 1'b0});
        run("divu", 4'd4, 32'd100, 32'd7, 10, 1'b0, -1,
            '{hi: 32'd2, lo: 32'd14, dz: 1'b0});
        run("multu_dis", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, -1,
            '{hi: 32'd2, lo: 32'd14, dz: 1'b0});
        run("multu_lated", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 2,
            '{hi: 32'hFFFFFFFE, lo: 32'h00000001, dz: 1'b0});
        run("div_negb", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 1'b0, -1,
            '{hi: 32'd1, lo: 32'hFFFFFFFD, dz: 1'b0});
        run("badop", 4'd15, 32'h1234, 32'h5678, 0, 1'b0, -1,
            '{hi: 32'd1, lo: 32'hFFFFFFFD, dz: 1'b0});
        run("pre_hi", 4'd5, 32'd0, 32'd0, 0, 1'b0, -1,
            '{hi: 32'd0, lo: 32'hFFFFFFFD, dz: 1'b0});
        run("pre_lo", 4'd6, 32'hFFFFFFFF, 32'd0, 0, 1'b0, -1,
            '{hi: 32'd0, lo: 32'hFFFFFFFF, dz: 1'b0});
`ifdef MULTDIV_MADD_EN
        run("maddu", 4'd8, 32'd1, 32'd1, 5, 1'b0, -1,
            '{hi: 32'd1, lo: 32'd0, dz: 1'b0});
`else
        run("maddu_off", 4'd8, 32'd1, 32'd1, 0, 1'b0, -1,
            '{hi: 32'd0, lo: 32'hFFFFFFFF, dz: 1'b0});
`endif

        chk("rst_mid/idle_before", busy, 0);
        start = 1'b1; op = 4'd3; rs_val = 32'd1000; rt_val = 32'd3;
        nxt();
        start = 1'b0; op = 4'd0;
        nxt();
        nxt();
        reset = 1'b1;
        #1;
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/hi", hi, 0);
        chk("rst_mid/lo", lo, 0);
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid/idle1", busy, 0);
        nxt();
        @(negedge clk);
        chk("rst_mid/idle2", busy, 0);
        nxt();
        run("mtlo5", 4'd6, 32'h5, 32'd0, 0, 1'b0, -1,
            '{hi: 32'd0, lo: 32'h5, dz: 1'b0});

        chk("sbq_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
